// File: rtl/stack_unit.sv
// LIFO stack with zero-latency top-of-stack read, same-cycle push+pop replace,
// and sticky overflow/underflow flags.
module stack_unit #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_enable,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_enable,
    output logic [WIDTH-1:0] pop_data,
    input  logic             clear_errors,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp, sp_nxt;
    logic [AW-1:0]    top_idx, wr_idx;
    logic             wr_en, ovf_set, unf_set;

    assign count   = sp;
    assign full    = (sp == CW'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = AW'(sp - CW'(1));
    assign pop_data = empty ? '0 : mem[top_idx];

    always_comb begin
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_idx  = AW'(sp);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case ({push_enable, pop_enable})
            2'b10: begin
                if (!full) begin
                    wr_en  = 1'b1;
                    sp_nxt = sp + CW'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) sp_nxt = sp - CW'(1);
                else        unf_set = 1'b1;
            end
            2'b11: begin
                // Replace the top in place; an empty stack degenerates to a push
                // that still reports the missing pop.
                wr_en = 1'b1;
                if (!empty) begin
                    wr_idx = top_idx;
                end else begin
                    wr_idx  = '0;
                    sp_nxt  = CW'(1);
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Storage is deliberately not reset; writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= sp_nxt;
            if (ovf_set)           overflow  <= 1'b1;
            else if (clear_errors) overflow  <= 1'b0;
            if (unf_set)           underflow <= 1'b1;
            else if (clear_errors) underflow <= 1'b0;
        end
    end

endmodule
